// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared types and constants for the iterative multiply/divide unit.
//   Holds the control state encoding, the fixed iteration counts and the
//   two operand values that trigger the divide overflow special case.
//   The last-iteration counter values are precomputed at the 5-bit counter
//   width so the FSM compares like-sized quantities.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  localparam logic [4:0] MULT_LAST = 5'(MULT_ITERS - 1);
  localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/multdiv_unit_booth.sv
// booth_r4_sel
//   Radix-4 modified Booth partial product selector (combinational).
//   Ports:
//     window_i [2:0]  Booth window {b[2i+1], b[2i], b[2i-1]}
//     a_i      [31:0] signed multiplicand
//     pp_o     [33:0] sign-extended partial product, ones-complemented
//                     when the selected multiple is negative
//     neg_o           negate flag; the consumer adds it as a carry-in so
//                     that pp_o + neg_o equals the true two's complement
//                     multiple (0, +A, -A, +2A or -2A)
module booth_r4_sel
  import multdiv_pkg::*;
(
  input  logic [2:0]  window_i,
  input  logic [31:0] a_i,
  output logic [33:0] pp_o,
  output logic        neg_o
);

  logic [33:0] aExt;
  logic [33:0] mag;
  logic        negSel;

  // Pick the magnitude (A or 2A) and the sign from the 3-bit window.
  // Windows 000 and 111 select zero and never negate.
  always_comb begin
    aExt   = {{2{a_i[31]}}, a_i};
    mag    = '0;
    negSel = 1'b0;
    case (window_i)
      3'b001, 3'b010: mag = aExt;
      3'b011:         mag = {aExt[32:0], 1'b0};
      3'b100: begin
        mag    = {aExt[32:0], 1'b0};
        negSel = 1'b1;
      end
      3'b101, 3'b110: begin
        mag    = aExt;
        negSel = 1'b1;
      end
      default: begin
        mag    = '0;
        negSel = 1'b0;
      end
    endcase
    pp_o  = negSel ? ~mag : mag;
    neg_o = negSel;
  end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
//   Iterative signed 32-bit multiply/divide unit for the execute stage.
//   Multiply: radix-4 modified Booth, 16 iterations, result is the low 32
//   bits of the product, exception flags signed overflow.
//   Divide: non-restoring division on operand magnitudes, 32 iterations,
//   quotient truncated toward zero with sign fix-up; divide-by-zero and
//   INT_MIN / -1 are resolved at accept and flagged as exceptions.
//   Configuration macro: MULTDIV_DIV_EN builds the divider datapath and
//   the DIV state; without it an accepted divide completes immediately
//   with result 0 and exception 1.
//   Ports:
//     clk         rising-edge clock
//     clr         synchronous active-high reset, aborts any operation
//     start_mult  start a multiply (sampled only in IDLE, has priority)
//     start_div   start a divide (sampled only in IDLE)
//     operand_a   signed multiplicand / dividend
//     operand_b   signed multiplier / divisor
//     result      registered result, held until the next completion
//     result_rdy  one-cycle pulse while in DONE
//     exception   registered exception flag, valid with result_rdy
//     busy        high in MULT, DIV and DONE
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        result_rdy,
  output logic        exception,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  // Multiply datapath: acc holds {partial product high 34 bits, multiplier
  // bits still to be consumed}; boothPrev is the implicit b[-1] bit.
  logic [65:0] acc_q, acc_d;
  logic        boothPrev_q, boothPrev_d;
  logic [31:0] mcand_q, mcand_d;

  logic [33:0] pp;
  logic        ppNeg;
  logic [33:0] hiSum;
  logic [65:0] accStep;

  booth_r4_sel u_booth (
    .window_i (({acc_q[1:0], boothPrev_q})),
    .a_i      (mcand_q),
    .pp_o     (pp),
    .neg_o    (ppNeg)
  );

  // One Booth step: add the selected multiple into the upper part, then
  // arithmetic shift the whole accumulator right by two.
  always_comb begin
    hiSum   = acc_q[65:32] + pp + {33'd0, ppNeg};
    accStep = {{2{hiSum[33]}}, hiSum, acc_q[31:2]};
  end

`ifdef MULTDIV_DIV_EN
  // Divide datapath: rem is the signed partial remainder, quo shifts the
  // dividend magnitude out at the top and quotient bits in at the bottom.
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negQ_q, negQ_d;

  logic [31:0] absA, absB;
  logic [32:0] remShift, remNext;
  logic [31:0] quoNext;

  // |INT_MIN| wraps back to 0x80000000, which is correct as an unsigned
  // magnitude.  The partial remainder never exceeds the divisor magnitude,
  // so dropping rem_q[32] on the left shift loses no information.
  always_comb begin
    absA     = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    absB     = operand_b[31] ? (32'd0 - operand_b) : operand_b;
    remShift = {rem_q[31:0], quo_q[31]};
    remNext  = rem_q[32] ? (remShift + {1'b0, dvsr_q})
                         : (remShift - {1'b0, dvsr_q});
    quoNext  = {quo_q[30:0], ~remNext[32]};
  end
`endif

  // State and datapath registers; clr wins over every transition.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      count_q     <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      acc_q       <= '0;
      boothPrev_q <= 1'b0;
      mcand_q     <= '0;
`ifdef MULTDIV_DIV_EN
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      negQ_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      acc_q       <= acc_d;
      boothPrev_q <= boothPrev_d;
      mcand_q     <= mcand_d;
`ifdef MULTDIV_DIV_EN
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      negQ_q      <= negQ_d;
`endif
    end
  end

  // Next-state and datapath control.  Result and exception are written on
  // the same edge that enters DONE so they line up with result_rdy.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    result_d    = result_q;
    exc_d       = exc_q;
    acc_d       = acc_q;
    boothPrev_d = boothPrev_q;
    mcand_d     = mcand_q;
`ifdef MULTDIV_DIV_EN
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    negQ_d      = negQ_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          mcand_d     = operand_a;
          acc_d       = {34'd0, operand_b};
          boothPrev_d = 1'b0;
          count_d     = '0;
          state_d     = MULT;
        end else if (start_div) begin
`ifdef MULTDIV_DIV_EN
          count_d = '0;
          rem_d   = '0;
          quo_d   = absA;
          dvsr_d  = absB;
          negQ_d  = operand_a[31] ^ operand_b[31];
          if (operand_b == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = DONE;
          end else if ((operand_a == INT_MIN) && (operand_b == NEG_ONE)) begin
            result_d = INT_MIN;
            exc_d    = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
`else
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = DONE;
`endif
        end
      end
      MULT: begin
        acc_d       = accStep;
        boothPrev_d = acc_q[1];
        count_d     = count_q + 5'd1;
        if (count_q == MULT_LAST) begin
          state_d  = DONE;
          result_d = accStep[31:0];
          // Overflow unless bits 63..31 are a pure sign extension.
          exc_d    = ~((&accStep[63:31]) | ~(|accStep[63:31]));
        end
      end
`ifdef MULTDIV_DIV_EN
      DIV: begin
        rem_d   = remNext;
        quo_d   = quoNext;
        count_d = count_q + 5'd1;
        if (count_q == DIV_LAST) begin
          state_d  = DONE;
          result_d = negQ_q ? (32'd0 - quoNext) : quoNext;
          exc_d    = 1'b0;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result     = result_q;
  assign exception  = exc_q;
  assign result_rdy = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule
